// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified instruction/data memory port between
// port 0 (CPU datapath) and port 1 (DMA/loader), one transaction at a time.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req/we/adr/wd{0,1}  requester transaction inputs, held until ack
//   ack{0,1}, rd{0,1}   one-cycle completion pulse and read data
//   mem_adr/mem_wd      latched memory address / write data
//   mem_we              one-cycle write strobe per write transaction
//   mem_rd              memory read data, valid MEM_LAT cycles after address
//   busy, owner         transaction in flight / port currently or last granted

module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] wd0,
    output logic          ack0,
    output logic [DW-1:0] rd0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wd1,
    output logic          ack1,
    output logic [DW-1:0] rd1,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    output logic          busy,
    output logic          owner
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
            $fatal(1, "mem_arbiter: MEM_LAT must be in 1..7");
        end
    endgenerate

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [2:0] cnt;
    logic       wflag;
    logic       first;
    logic       grant;
    logic       gport;

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        gport   = owner;
        busy    = 1'b0;
        mem_we  = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        rd0     = '0;
        rd1     = '0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant   = 1'b1;
                    // Contention goes to the port that did not win last.
                    gport   = (req0 && req1) ? ~owner : req1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                busy   = 1'b1;
                // Strobe only once so a multi-cycle access writes once.
                mem_we = wflag & first;
                if (cnt == 3'd0) begin
                    state_n = IDLE;
                    if (owner) begin
                        ack1 = 1'b1;
                        rd1  = mem_rd;
                    end else begin
                        ack0 = 1'b1;
                        rd0  = mem_rd;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 3'd0;
            owner   <= 1'b1;
            wflag   <= 1'b0;
            first   <= 1'b0;
            mem_adr <= '0;
            mem_wd  <= '0;
        end else if (grant) begin
            mem_adr <= gport ? adr1 : adr0;
            mem_wd  <= gport ? wd1 : wd0;
            wflag   <= gport ? we1 : we0;
            owner   <= gport;
            cnt     <= CNT_INIT;
            first   <= 1'b1;
        end else if (state == BUSY) begin
            first <= 1'b0;
            if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter at MEM_LAT = 1 and 3.
// Two instances share requester inputs; each has its own memory model.

module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        mclr;
    logic        req0, we0, req1, we1;
    logic [31:0] adr0, wd0, adr1, wd1;

    logic        ack0_a, ack1_a, mem_we_a, busy_a, owner_a;
    logic [31:0] rd0_a, rd1_a, mem_adr_a, mem_wd_a, mem_rd_a;
    logic        ack0_b, ack1_b, mem_we_b, busy_b, owner_b;
    logic [31:0] rd0_b, rd1_b, mem_adr_b, mem_wd_b, mem_rd_b;

    int vec;
    int errs;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_a (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0),
        .ack0(ack0_a), .rd0(rd0_a),
        .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1),
        .ack1(ack1_a), .rd1(rd1_a),
        .mem_adr(mem_adr_a), .mem_wd(mem_wd_a), .mem_we(mem_we_a),
        .mem_rd(mem_rd_a), .busy(busy_a), .owner(owner_a)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_b (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0),
        .ack0(ack0_b), .rd0(rd0_b),
        .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1),
        .ack1(ack1_b), .rd1(rd1_b),
        .mem_adr(mem_adr_b), .mem_wd(mem_wd_b), .mem_we(mem_we_b),
        .mem_rd(mem_rd_b), .busy(busy_b), .owner(owner_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten words read back as a known address-dependent pattern.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return 32'hDEAD_BEEF + a - 32'h10;
    endfunction

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [255:0] vld_a;
    logic [255:0] vld_b;

    always @(posedge clk) begin
        if (mclr) begin
            vld_a <= '0;
        end else if (mem_we_a) begin
            mem_a[mem_adr_a[9:2]] <= mem_wd_a;
            vld_a[mem_adr_a[9:2]] <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (mclr) begin
            vld_b <= '0;
        end else if (mem_we_b) begin
            mem_b[mem_adr_b[9:2]] <= mem_wd_b;
            vld_b[mem_adr_b[9:2]] <= 1'b1;
        end
    end

    assign mem_rd_a = vld_a[mem_adr_a[9:2]] ? mem_a[mem_adr_a[9:2]]
                                             : dflt(mem_adr_a);
    assign mem_rd_b = vld_b[mem_adr_b[9:2]] ? mem_b[mem_adr_b[9:2]]
                                             : dflt(mem_adr_b);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req0  = 1'b0;
        req1  = 1'b0;
        we0   = 1'b0;
        we1   = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            vec++;
            if ({busy_a, mem_we_a, ack0_a, ack1_a} !== 4'b0000) begin
                errs++;
                $display("FAIL reset_idle cyc %0d: busy/we/ack0/ack1=%b want 0000",
                         i, {busy_a, mem_we_a, ack0_a, ack1_a});
            end
            vec++;
            if (owner_a !== 1'b1) begin
                errs++;
                $display("FAIL reset_owner cyc %0d: got %b want 1", i, owner_a);
            end
        end
        vec++;
        if (mem_adr_a !== 32'h0 || mem_wd_a !== 32'h0) begin
            errs++;
            $display("FAIL reset_mem_bus: adr=%h wd=%h want 0", mem_adr_a, mem_wd_a);
        end
        vec++;
        if (owner_b !== 1'b1 || busy_b !== 1'b0) begin
            errs++;
            $display("FAIL reset_lat3: owner=%b busy=%b want 1/0", owner_b, busy_b);
        end
    endtask

    task automatic test_read0;
        int nack;
        int n1;
        int lat;
        nack = 0;
        n1   = 0;
        lat  = 0;
        do_reset();
        e.port = 1'b0;
        e.data = 32'hDEAD_BEEF;
        sb.push_back(e);
        adr0 = 32'h10;
        we0  = 1'b0;
        req0 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (ack1_a) n1++;
            if (ack0_a) begin
                nack++;
                lat = n + 1;
                vec++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL read0_extra: unexpected ack0 at cyc %0d", n);
                end else begin
                    e = sb.pop_front();
                    if (rd0_a !== e.data) begin
                        errs++;
                        $display("FAIL read0_data: got %h want %h", rd0_a, e.data);
                    end
                end
                req0 = 1'b0;
            end
        end
        vec++;
        if (nack !== 1) begin
            errs++;
            $display("FAIL read0_count: got %0d acks want 1", nack);
        end
        vec++;
        if (lat !== 2) begin
            errs++;
            $display("FAIL read0_latency: got %0d want 2", lat);
        end
        vec++;
        if (n1 !== 0) begin
            errs++;
            $display("FAIL read0_ack1: got %0d ack1 pulses want 0", n1);
        end
        req0 = 1'b0;
        sb.delete();
    endtask

    task automatic test_write1;
        int wcnt;
        int nack;
        wcnt = 0;
        nack = 0;
        do_reset();
        adr1 = 32'h100;
        wd1  = 32'h1234_5678;
        we1  = 1'b1;
        req1 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (mem_we_a) begin
                wcnt++;
                vec++;
                if (mem_adr_a !== 32'h100 || mem_wd_a !== 32'h1234_5678) begin
                    errs++;
                    $display("FAIL write1_bus: adr=%h wd=%h want 00000100/12345678",
                             mem_adr_a, mem_wd_a);
                end
            end
            if (ack1_a) begin
                nack++;
                req1 = 1'b0;
                we1  = 1'b0;
            end
        end
        vec++;
        if (wcnt !== 1) begin
            errs++;
            $display("FAIL write1_strobes: got %0d want 1", wcnt);
        end
        vec++;
        if (nack !== 1) begin
            errs++;
            $display("FAIL write1_ack: got %0d want 1", nack);
        end
        e.port = 1'b0;
        e.data = 32'h1234_5678;
        sb.push_back(e);
        adr0 = 32'h100;
        we0  = 1'b0;
        req0 = 1'b1;
        nack = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (ack0_a) begin
                nack++;
                vec++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL readback_extra: unexpected ack0");
                end else begin
                    e = sb.pop_front();
                    if (rd0_a !== e.data) begin
                        errs++;
                        $display("FAIL readback_data: got %h want %h", rd0_a, e.data);
                    end
                end
                req0 = 1'b0;
            end
        end
        vec++;
        if (nack !== 1) begin
            errs++;
            $display("FAIL readback_count: got %0d want 1", nack);
        end
        req0 = 1'b0;
        sb.delete();
    endtask

    task automatic test_round_robin;
        int nack;
        int last;
        nack = 0;
        last = 0;
        do_reset();
        adr0 = 32'h10;
        adr1 = 32'h40;
        we0  = 1'b0;
        we1  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            e.port = k[0];
            e.data = k[0] ? dflt(32'h40) : dflt(32'h10);
            sb.push_back(e);
        end
        req0 = 1'b1;
        req1 = 1'b1;
        for (int n = 1; n <= 40 && nack < 6; n++) begin
            tick();
            if (ack0_a || ack1_a) begin
                vec++;
                if (ack0_a && ack1_a) begin
                    errs++;
                    $display("FAIL rr_both_ack at cyc %0d", n);
                end
                vec++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL rr_extra_ack at cyc %0d", n);
                end else begin
                    e = sb.pop_front();
                    if (ack1_a !== e.port) begin
                        errs++;
                        $display("FAIL rr_order #%0d: got port %b want %b",
                                 nack, ack1_a, e.port);
                    end
                    vec++;
                    if ((ack1_a ? rd1_a : rd0_a) !== e.data) begin
                        errs++;
                        $display("FAIL rr_data #%0d: got %h want %h", nack,
                                 ack1_a ? rd1_a : rd0_a, e.data);
                    end
                end
                vec++;
                if ((ack1_a ? rd0_a : rd1_a) !== 32'h0) begin
                    errs++;
                    $display("FAIL rr_idle_rd #%0d: got %h want 0", nack,
                             ack1_a ? rd0_a : rd1_a);
                end
                if (nack > 0) begin
                    vec++;
                    if (n - last !== 2) begin
                        errs++;
                        $display("FAIL rr_spacing #%0d: got %0d want 2",
                                 nack, n - last);
                    end
                end
                last = n;
                nack++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        vec++;
        if (nack !== 6) begin
            errs++;
            $display("FAIL rr_count: got %0d want 6", nack);
        end
        sb.delete();
    endtask

    task automatic test_lat3;
        int nack;
        int lat;
        nack = 0;
        lat  = 0;
        do_reset();
        e.port = 1'b1;
        e.data = dflt(32'h40);
        sb.push_back(e);
        adr1 = 32'h40;
        we1  = 1'b0;
        req1 = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 3) begin
                vec++;
                if (mem_adr_b !== 32'h40) begin
                    errs++;
                    $display("FAIL lat3_adr_hold: got %h want 00000040", mem_adr_b);
                end
            end
            if (ack1_b) begin
                nack++;
                lat = n + 1;
                vec++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL lat3_extra: unexpected ack1");
                end else begin
                    e = sb.pop_front();
                    if (rd1_b !== e.data) begin
                        errs++;
                        $display("FAIL lat3_data: got %h want %h", rd1_b, e.data);
                    end
                end
                req1 = 1'b0;
            end
            if (n == 2) adr1 = 32'h80;
        end
        vec++;
        if (nack !== 1 || lat !== 4) begin
            errs++;
            $display("FAIL lat3_latency: acks=%0d lat=%0d want 1/4", nack, lat);
        end
        req1 = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset_mid;
        int nack;
        int lat;
        nack = 0;
        lat  = 0;
        do_reset();
        adr0 = 32'h10;
        we0  = 1'b0;
        req0 = 1'b1;
        tick();
        if (ack0_b) nack++;
        tick();
        if (ack0_b) nack++;
        reset = 1'b1;
        tick();
        if (ack0_b) nack++;
        vec++;
        if (nack !== 0) begin
            errs++;
            $display("FAIL rstmid_ack: got %0d acks want 0", nack);
        end
        vec++;
        if (busy_b !== 1'b0 || owner_b !== 1'b1) begin
            errs++;
            $display("FAIL rstmid_state: busy=%b owner=%b want 0/1", busy_b, owner_b);
        end
        reset = 1'b0;
        e.port = 1'b0;
        e.data = 32'hDEAD_BEEF;
        sb.push_back(e);
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (ack0_b) begin
                nack++;
                lat = n + 1;
                vec++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL rstmid_extra: unexpected ack0");
                end else begin
                    e = sb.pop_front();
                    if (rd0_b !== e.data) begin
                        errs++;
                        $display("FAIL rstmid_data: got %h want %h", rd0_b, e.data);
                    end
                end
                req0 = 1'b0;
            end
        end
        vec++;
        if (nack !== 1 || lat !== 4) begin
            errs++;
            $display("FAIL rstmid_reserve: acks=%0d lat=%0d want 1/4", nack, lat);
        end
        req0 = 1'b0;
        sb.delete();
    endtask

    initial begin
        vec   = 0;
        errs  = 0;
        reset = 1'b1;
        mclr  = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        we0   = 1'b0;
        we1   = 1'b0;
        adr0  = '0;
        adr1  = '0;
        wd0   = '0;
        wd1   = '0;
        tick();
        mclr = 1'b0;
        test_reset();
        test_read0();
        test_write1();
        test_round_robin();
        test_lat3();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
